// File: rtl/stereo_frame_source_if.sv
// -----------------------------------------------------------------------------
// stereo_frame_source_if
// Pixel-stream bus between the stereo frame source and its consumer.
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once the source raises out_valid it holds
// out_valid, pix_l, pix_r, sof, eol and eof stable until that transfer.
// out_ready may change freely and is never used to compute out_valid.
//
// Signals
//   out_valid  source -> sink   beat valid
//   out_ready  sink   -> source sink accepts the beat
//   pix_l      source -> sink   left pixel  (PIX_D bits)
//   pix_r      source -> sink   right pixel (PIX_D bits)
//   sof        source -> sink   beat is pixel (0,0)
//   eol        source -> sink   beat is last pixel of a line
//   eof        source -> sink   beat is last pixel of the frame
// -----------------------------------------------------------------------------
interface stereo_frame_source_if #(
    parameter int PIX_D = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [PIX_D-1:0] pix_l;
    logic [PIX_D-1:0] pix_r;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (
        output out_valid, pix_l, pix_r, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, pix_l, pix_r, sof, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/stereo_frame_source.sv
// -----------------------------------------------------------------------------
// stereo_frame_source
// Parametrised stereo pixel-stream generator. Emits paired left/right frames
// where the right image is the left image shifted by a programmable disparity,
// with SOF/EOL/EOF markers, line/frame blanking and valid/ready backpressure.
// The disparity ground truth is therefore known by construction.
//
// Optional feature macro: STEREO_SRC_NOISE_EN
//   defined     -> a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1
//                  on reset, never reseeded per frame) steps on every accepted
//                  beat; its bit 0 is XORed into the LSB of in-range right pixels.
//   not defined -> no LFSR, right pixels are exact.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous, active-high reset (dominates all)
//   enable     in   1       run request, sampled in IDLE and VBLANK only
//   disp       in   DISP_W  disparity, latched when a frame starts
//   mode       in   2       pattern: 0 gradient, 1 checker, 2 hash, 3 FILL_VAL
//   frame_cnt  out  16      completed frames, wraps at 2^16
//   state_dbg  out  2       current FSM state (0 IDLE,1 ACTIVE,2 HBLANK,3 VBLANK)
//   bus        master       out_valid/out_ready/pix_l/pix_r/sof/eol/eof
// -----------------------------------------------------------------------------
module stereo_frame_source #(
    parameter int               IMG_W    = 8,
    parameter int               IMG_H    = 8,
    parameter int               PIX_D    = 4,
    parameter int               DISP_W   = 4,
    parameter int               HBLANK   = 2,
    parameter int               VBLANK   = 4,
    parameter int               BLK_LOG2 = 1,
    parameter logic [PIX_D-1:0] FILL_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DISP_W-1:0]   disp,
    input  logic [1:0]          mode,
    output logic [15:0]         frame_cnt,
    output logic [1:0]          state_dbg,
    stereo_frame_source_if.master bus
);

    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW   = DISP_W + XW + 1;
    localparam int MAXB = (HBLANK > VBLANK) ? ((HBLANK > 1) ? HBLANK : 1)
                                            : ((VBLANK > 1) ? VBLANK : 1);
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [XW-1:0] LAST_X  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] LAST_Y  = YW'(IMG_H - 1);
    localparam logic [CW-1:0] HB_LOAD = CW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [CW-1:0] VB_LOAD = CW'((VBLANK > 0) ? VBLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [DISP_W-1:0] disp_q;
    logic [1:0]        mode_q;
    logic [CW-1:0]     cnt;

    // Pattern f(x,y) evaluated in 32 bits and truncated to PIX_D.
    function automatic logic [PIX_D-1:0] pat(input logic [1:0] m,
                                             input logic [31:0] px,
                                             input logic [31:0] py);
        logic [31:0] v;
        case (m)
            2'd0:    v = px + py;
            2'd1:    v = (((px >> BLK_LOG2) ^ (py >> BLK_LOG2)) & 32'd1) != 0 ? '1 : '0;
            2'd2:    v = (px * 32'd5) ^ (py * 32'd3) ^ (px >> 2) ^ (py << 1);
            default: v = 32'(FILL_VAL);
        endcase
        return v[PIX_D-1:0];
    endfunction

    // Right pixel: shifted sample, or FILL_VAL once x+disp leaves the line.
    // The sum is wide enough that it never wraps back into range.
    function automatic logic [PIX_D-1:0] pat_r(input logic [1:0] m,
                                               input logic [DISP_W-1:0] d,
                                               input logic [31:0] px,
                                               input logic [31:0] py,
                                               input logic nb);
        logic [SW-1:0] s;
        s = SW'(px) + SW'(d);
        if (32'(s) < 32'(IMG_W))
            return pat(m, 32'(s), py) ^ PIX_D'(nb);
        else
            return FILL_VAL;
    endfunction

    logic accept;
    logic noise_cur;   // noise bit for a beat loaded without an accept this cycle
    logic noise_adv;   // noise bit for the beat following an accept
    assign accept = bus.out_valid & bus.out_ready;

`ifdef STEREO_SRC_NOISE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (accept)
            lfsr <= lfsr_nxt;
    end
    assign noise_cur = lfsr[0];
    assign noise_adv = lfsr_nxt[0];
`else
    assign noise_cur = 1'b0;
    assign noise_adv = 1'b0;
`endif

    // Coordinates of the beat after an accept (only used inside a frame).
    logic [XW-1:0] adv_x;
    logic [YW-1:0] adv_y;
    logic          at_eol;
    logic          at_eof;
    always_comb begin
        adv_x = x + XW'(1);
        adv_y = y;
        if (x == LAST_X) begin
            adv_x = '0;
            adv_y = y + YW'(1);
        end
    end
    assign at_eol = (x == LAST_X);
    assign at_eof = at_eol && (y == LAST_Y);

    // Candidate beats: frame start (fresh disp/mode), advance, line resume.
    logic [PIX_D-1:0] start_l, start_r, adv_l, adv_r, res_l, res_r;
    logic             adv_eol, adv_eof;
    assign start_l = pat(mode, 32'd0, 32'd0);
    assign start_r = pat_r(mode, disp, 32'd0, 32'd0, noise_cur);
    assign adv_l   = pat(mode_q, 32'(adv_x), 32'(adv_y));
    assign adv_r   = pat_r(mode_q, disp_q, 32'(adv_x), 32'(adv_y), noise_adv);
    assign res_l   = pat(mode_q, 32'(x), 32'(y));
    assign res_r   = pat_r(mode_q, disp_q, 32'(x), 32'(y), noise_cur);
    assign adv_eol = (adv_x == LAST_X);
    assign adv_eof = adv_eol && (adv_y == LAST_Y);

    // A new frame begins from IDLE, at the end of VBLANK, or straight after
    // the eof beat when there is no frame blanking at all.
    logic start_now;
    assign start_now = enable &&
                       ((state == S_IDLE) ||
                        (state == S_VBLANK && cnt == '0) ||
                        (state == S_ACTIVE && accept && at_eof && VBLANK == 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            disp_q        <= '0;
            mode_q        <= '0;
            cnt           <= '0;
            frame_cnt     <= '0;
            bus.out_valid <= 1'b0;
            bus.pix_l     <= '0;
            bus.pix_r     <= '0;
            bus.sof       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.eof       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_ACTIVE: begin
                    if (accept) begin
                        if (at_eof) begin
                            frame_cnt     <= frame_cnt + 16'd1;
                            x             <= '0;
                            y             <= '0;
                            bus.out_valid <= 1'b0;
                            bus.sof       <= 1'b0;
                            bus.eol       <= 1'b0;
                            bus.eof       <= 1'b0;
                            if (VBLANK == 0) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_VBLANK;
                                cnt   <= VB_LOAD;
                            end
                        end else if (at_eol && HBLANK != 0) begin
                            x             <= adv_x;
                            y             <= adv_y;
                            bus.out_valid <= 1'b0;
                            bus.sof       <= 1'b0;
                            bus.eol       <= 1'b0;
                            state         <= S_HBLANK;
                            cnt           <= HB_LOAD;
                        end else begin
                            x         <= adv_x;
                            y         <= adv_y;
                            bus.pix_l <= adv_l;
                            bus.pix_r <= adv_r;
                            bus.sof   <= 1'b0;
                            bus.eol   <= adv_eol;
                            bus.eof   <= adv_eof;
                        end
                    end
                end
                S_HBLANK: begin
                    if (cnt == '0) begin
                        state         <= S_ACTIVE;
                        bus.out_valid <= 1'b1;
                        bus.pix_l     <= res_l;
                        bus.pix_r     <= res_r;
                        bus.sof       <= 1'b0;
                        bus.eol       <= 1'b0;
                        bus.eof       <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_VBLANK: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= S_IDLE;
            endcase

            // Frame start overrides whatever the case above chose.
            if (start_now) begin
                state         <= S_ACTIVE;
                x             <= '0;
                y             <= '0;
                disp_q        <= disp;
                mode_q        <= mode;
                bus.out_valid <= 1'b1;
                bus.pix_l     <= start_l;
                bus.pix_r     <= start_r;
                bus.sof       <= 1'b1;
                bus.eol       <= 1'b0;
                bus.eof       <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_stereo_frame_source.sv
// -----------------------------------------------------------------------------
// tb_stereo_frame_source
// Directed bench for stereo_frame_source with default parameters
// (8x8 frame, 4-bit pixels, HBLANK 2, VBLANK 4, 2-pixel checker blocks).
// -----------------------------------------------------------------------------
module tb_stereo_frame_source;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  disp = '0;
    logic [1:0]  mode = '0;
    logic [15:0] frame_cnt;
    logic [1:0]  state_dbg;

    stereo_frame_source_if #(.PIX_D(4)) bus ();

    stereo_frame_source dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .disp      (disp),
        .mode      (mode),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_lfsr = 16'hACE1;
    logic [3:0]  row1_l [W];
    logic [3:0]  row1_r [W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int fpat(input int m, input int x, input int y);
        case (m)
            0:       return (x + y) & 15;
            1:       return (((x >> 1) ^ (y >> 1)) & 1) ? 15 : 0;
            2:       return ((x * 5) ^ (y * 3) ^ (x >> 2) ^ (y << 1)) & 15;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ---------------- driver / monitor ----------------
    // Pulls nb beats out of the DUT. Checks every accepted beat against the
    // model, the line gap before every line but the first, and that a
    // stalled beat does not move.
    task automatic collect_frame(input int d, input int m, input bit rnd, input int nb,
                                 input int disp_chg_at, input int en_drop_at);
        int          beats = 0;
        int          cyc = 0;
        int          gap = 0;
        int          x;
        int          y;
        int          exp_r;
        bit          stalled = 1'b0;
        logic [11:0] snap = '0;
        logic [11:0] now;
        while (beats < nb && cyc < 3000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            now = {bus.out_valid, bus.sof, bus.eol, bus.eof, bus.pix_l, bus.pix_r};
            if (stalled) begin
                check("stall_hold", now, snap);
                stalled = 1'b0;
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    x = beats % W;
                    y = beats / W;
                    exp_r = (x + d < W) ? fpat(m, x + d, y) : 0;
`ifdef STEREO_SRC_NOISE_EN
                    if (x + d < W) exp_r = exp_r ^ int'(ref_lfsr[0]);
                    ref_lfsr = lfsr_step(ref_lfsr);
`endif
                    check("pix_l", bus.pix_l, fpat(m, x, y));
                    check("pix_r", bus.pix_r, exp_r);
                    check("sof", bus.sof, (x == 0 && y == 0));
                    check("eol", bus.eol, (x == W - 1));
                    check("eof", bus.eof, (x == W - 1 && y == H - 1));
                    if (x == 0 && y > 0) check("hblank_gap", gap, 2);
                    if (y == 1) begin
                        row1_l[x] = bus.pix_l;
                        row1_r[x] = bus.pix_r;
                    end
                    beats++;
                    gap = 0;
                    if (beats == disp_chg_at) disp = 4'd5;
                    if (beats == en_drop_at) enable = 1'b0;
                end else begin
                    snap = now;
                    stalled = 1'b1;
                end
            end else begin
                gap++;
            end
            tick;
            cyc++;
        end
        bus.out_ready = 1'b1;
        check("frame_beats", beats, nb);
    endtask

    task automatic wait_valid(output int g);
        g = 0;
        while (!bus.out_valid && g < 50) begin
            tick;
            g++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int g;
        logic [3:0] exp_row_r [W];
        exp_row_r = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0};
        bus.out_ready = 1'b1;

        // reset state
        tick;
        tick;
        check("rst_valid", bus.out_valid, 0);
        check("rst_pix_l", bus.pix_l, 0);
        check("rst_pix_r", bus.pix_r, 0);
        check("rst_sof", bus.sof, 0);
        check("rst_eol", bus.eol, 0);
        check("rst_eof", bus.eof, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        ref_lfsr = 16'hACE1;
        tick;
        check("idle_no_valid", bus.out_valid, 0);

        // T1: gradient, disp 0, ready always
        enable = 1'b1;
        tick;
        check("start_valid", bus.out_valid, 1);
        check("start_sof", bus.sof, 1);
        collect_frame(0, 0, 1'b0, 64, -1, -1);
        check("t1_vblank_valid", bus.out_valid, 0);
        check("t1_frame_cnt", frame_cnt, 1);
        for (int i = 0; i < W; i++) begin
            check("t1_row1_l", row1_l[i], i + 1);
            check("t1_row1_r", row1_r[i], i + 1);
        end
        wait_valid(g);
        check("t1_vblank_gap", g, 4);

        // T3: same frame under random backpressure
        collect_frame(0, 0, 1'b1, 64, -1, -1);
        check("t3_frame_cnt", frame_cnt, 2);
        disp = 4'd2;
        wait_valid(g);
        check("t3_vblank_gap", g, 4);

        // T2 + T4: disp 2, changed to 5 after beat 20 (applies next frame)
        collect_frame(2, 0, 1'b0, 64, 20, -1);
        for (int i = 0; i < W; i++) begin
            check("t2_row1_l", row1_l[i], i + 1);
`ifndef STEREO_SRC_NOISE_EN
            check("t2_row1_r", row1_r[i], exp_row_r[i]);
`endif
        end
        check("t2_frame_cnt", frame_cnt, 3);
        wait_valid(g);
        check("t4_vblank_gap", g, 4);
        collect_frame(5, 0, 1'b0, 11, -1, -1);

        // T5: one-cycle reset mid-line
        rst = 1'b1;
        tick;
        check("t5_valid", bus.out_valid, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        check("t5_state", state_dbg, 0);
        rst = 1'b0;
        ref_lfsr = 16'hACE1;
        mode = 2'd1;
        disp = 4'd3;
        tick;
        check("t5_restart_valid", bus.out_valid, 1);
        check("t5_restart_sof", bus.sof, 1);

        // checker frame, enable dropped mid-frame: frame completes then IDLE
        collect_frame(3, 1, 1'b0, 64, -1, 10);
        check("drop_frame_cnt", frame_cnt, 1);
        g = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) g++;
            tick;
        end
        check("drop_no_restart", g, 0);
        check("drop_state_idle", state_dbg, 0);

        // hash pattern with large disparity (mostly FILL_VAL on the right)
        mode = 2'd2;
        disp = 4'd7;
        enable = 1'b1;
        tick;
        check("hash_sof", bus.sof, 1);
        collect_frame(7, 2, 1'b0, 64, -1, -1);
        check("hash_frame_cnt", frame_cnt, 2);

        // T6: constant mode (right LSB carries noise when enabled)
        mode = 2'd3;
        disp = 4'd0;
        wait_valid(g);
        check("const_vblank_gap", g, 4);
        collect_frame(0, 3, 1'b0, 64, -1, -1);
        check("const_frame_cnt", frame_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
